// File: rtl/tick_gen.sv
// tick_gen: parametrised clock-enable generator.
//
// A runtime-programmable base divider produces tick[0]; NSTAGE fixed-ratio
// stages of SUB_DIV each produce tick[1..NSTAGE]. All ticks are registered,
// single-cycle clock enables. The design never gates the clock.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   en          count enable; all counters freeze while low
//   clr         synchronous clear of all counters (applies a pending divisor)
//   div_wr      load strobe for the base divisor shadow register
//   div_val     new base period in cycles (0 is treated as 1)
//   div_pending a written divisor is waiting for the next base terminal count
//   period      currently active base period
//   tick        tick[0] = base tick, tick[k] = cascade stage k
//   sq          (TICK_GEN_SQUARE_EN only) 50% square wave, toggles on each tick[k]
//
// Optional feature macro: TICK_GEN_SQUARE_EN adds the sq output.

module tick_gen #(
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned DEFAULT_DIV = 100000,
  parameter int unsigned SUB_DIV     = 10,
  parameter int unsigned NSTAGE      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic              div_wr,
  input  logic [CNT_W-1:0]  div_val,
  output logic              div_pending,
  output logic [CNT_W-1:0]  period,
  output logic [NSTAGE:0]   tick
`ifdef TICK_GEN_SQUARE_EN
  ,
  output logic [NSTAGE:0]   sq
`endif
);

  localparam int unsigned      SW     = $clog2(SUB_DIV);
  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);
  localparam logic [SW-1:0]    SubMax = SW'(SUB_DIV - 1);

  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  // scnt_q[i] is cascade stage i+1
  logic [SW-1:0]    scnt_q [NSTAGE];
  logic [SW-1:0]    scnt_d [NSTAGE];
  logic [NSTAGE:0]  tc;
  logic [NSTAGE:0]  tick_q;
  logic [CNT_W-1:0] div_sat;

  assign div_sat = (div_val == '0) ? One : div_val;

  // Terminal counts; clr suppresses them so no tick follows a cleared count.
  always_comb begin
    tc    = '0;
    tc[0] = en & ~clr & (bcnt_q == period_q - One);
    for (int k = 1; k <= NSTAGE; k++) begin
      tc[k] = tc[k-1] & (scnt_q[k-1] == SubMax);
    end
  end

  always_comb begin
    bcnt_d    = bcnt_q;
    period_d  = period_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    for (int i = 0; i < NSTAGE; i++) begin
      scnt_d[i] = scnt_q[i];
    end

    if (clr) begin
      bcnt_d = '0;
      for (int i = 0; i < NSTAGE; i++) begin
        scnt_d[i] = '0;
      end
      if (pending_q) begin
        period_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else if (en) begin
      bcnt_d = tc[0] ? '0 : bcnt_q + One;
      // New period only takes effect at a wrap, so the running period completes.
      if (tc[0] && pending_q) begin
        period_d  = shadow_q;
        pending_d = 1'b0;
      end
      for (int i = 0; i < NSTAGE; i++) begin
        if (tc[i]) begin
          scnt_d[i] = tc[i+1] ? '0 : scnt_q[i] + SW'(1);
        end
      end
    end

    // A write in the same cycle as an application stays pending for the next wrap.
    if (div_wr) begin
      shadow_d  = div_sat;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt_q    <= '0;
      period_q  <= DefDiv;
      shadow_q  <= DefDiv;
      pending_q <= 1'b0;
      tick_q    <= '0;
      for (int i = 0; i < NSTAGE; i++) begin
        scnt_q[i] <= '0;
      end
    end else begin
      bcnt_q    <= bcnt_d;
      period_q  <= period_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      tick_q    <= tc;
      for (int i = 0; i < NSTAGE; i++) begin
        scnt_q[i] <= scnt_d[i];
      end
    end
  end

  assign tick        = tick_q;
  assign period      = period_q;
  assign div_pending = pending_q;

`ifdef TICK_GEN_SQUARE_EN
  logic [NSTAGE:0] sq_q;

  // Toggles on the same edge that raises tick[k].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sq_q <= '0;
    end else if (clr) begin
      sq_q <= '0;
    end else begin
      sq_q <= sq_q ^ tc;
    end
  end

  assign sq = sq_q;
`else
  // No square-wave output in this build.
`endif

endmodule
